// File: rtl/rsa_panel_pkg.sv
// Shared definitions for the RSA front-panel controller: command codes and
// scheduler state encoding.
package rsa_panel_pkg;

  localparam logic [1:0] CMD_UP   = 2'd0;
  localparam logic [1:0] CMD_DOWN = 2'd1;
  localparam logic [1:0] CMD_LOAD = 2'd2;
  localparam logic [1:0] CMD_RUN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/btn_debounce_edge.sv
// Debounces one raw button level on the slow sample tick and emits a one-clk
// press pulse when the accepted (stable) level rises 0->1.
module btn_debounce_edge #(
  parameter int STABLE_TICKS = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_press
);

  logic [3:0] r_cnt;
  logic       r_level;
  logic       r_press;
  logic       w_accept;

  // The pending level change is accepted on the tick that completes the run
  // of consecutive differing samples.
  assign w_accept = i_tick && (i_raw != r_level) &&
                    ((r_cnt + 4'd1) == 4'(STABLE_TICKS));

  // Counter and stable level advance only on sample ticks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= w_accept && i_raw;
      if (i_tick) begin
        if (i_raw == r_level) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_cnt   <= '0;
          r_level <= i_raw;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/btn_cmd_scheduler.sv
// Front-panel command scheduler: four debounced buttons feed pending flags,
// a fixed-priority FSM executes one command at a time against the address
// register, the key-memory read port and the RSA core handshake.
module btn_cmd_scheduler
  import rsa_panel_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int ADDR_MAX     = 15,
  parameter int STABLE_TICKS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_load,
  input  logic              btn_run,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              core_start,
  input  logic              core_done,
  output logic [ADDR_W-1:0] address,
  output logic              operation,
  output logic [1:0]        cmd_code,
  output logic              busy
);

  state_e              r_state, w_state_nx;
  logic [3:0]          r_pend;
  logic [3:0]          w_raw, w_press, w_consume;
  logic [ADDR_W-1:0]   r_addr, w_addr_nx;
  logic                r_op, w_op_nx;
  logic [1:0]          r_code, w_code_nx;

  // Bit index of each button equals its command code.
  assign w_raw = {btn_run, btn_load, btn_down, btn_up};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce_edge #(.STABLE_TICKS(STABLE_TICKS)) u_db (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_tick  (sample_tick),
      .i_raw   (w_raw[g]),
      .o_press (w_press[g])
    );
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nx;
  end

  // Priority select (RUN > LOAD > UP > DOWN) and next-state decode.
  always_comb begin
    w_state_nx = r_state;
    w_consume  = '0;
    w_op_nx    = 1'b0;
    w_code_nx  = r_code;
    w_addr_nx  = r_addr;
    case (r_state)
      ST_IDLE: begin
        if (|r_pend) begin
          w_op_nx = 1'b1;
          if (r_pend[CMD_RUN]) begin
            w_code_nx          = CMD_RUN;
            w_consume[CMD_RUN] = 1'b1;
            w_state_nx         = ST_START;
          end else if (r_pend[CMD_LOAD]) begin
            w_code_nx           = CMD_LOAD;
            w_consume[CMD_LOAD] = 1'b1;
            w_state_nx          = ST_RD;
          end else if (r_pend[CMD_UP]) begin
            w_code_nx         = CMD_UP;
            w_consume[CMD_UP] = 1'b1;
            w_addr_nx = (r_addr == ADDR_W'(ADDR_MAX)) ? '0 : r_addr + 1'b1;
          end else begin
            w_code_nx           = CMD_DOWN;
            w_consume[CMD_DOWN] = 1'b1;
            w_addr_nx = (r_addr == '0) ? ADDR_W'(ADDR_MAX) : r_addr - 1'b1;
          end
        end
      end
      ST_RD:    if (mem_rd_ack) w_state_nx = ST_IDLE;
      // core_done in the start cycle is deliberately not looked at.
      ST_START: w_state_nx = ST_WAIT;
      ST_WAIT:  if (core_done) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // Pending flags, address and operation/cmd_code registers; consume beats a
  // same-cycle press of the same button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      r_addr <= '0;
      r_op   <= 1'b0;
      r_code <= '0;
    end else begin
      r_pend <= (r_pend | w_press) & ~w_consume;
      r_addr <= w_addr_nx;
      r_op   <= w_op_nx;
      r_code <= w_code_nx;
    end
  end

  assign mem_rd_req = (r_state == ST_RD);
  assign mem_addr   = mem_rd_req ? r_addr : '0;
  assign core_start = (r_state == ST_START);
  assign busy       = (r_state != ST_IDLE);
  assign address    = r_addr;
  assign operation  = r_op;
  assign cmd_code   = r_code;

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// Directed bench for btn_cmd_scheduler with a scoreboard of accepted commands.
module tb_btn_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0, btn_run = 1'b0;
  logic       mem_rd_req;
  logic       mem_rd_ack = 1'b0;
  logic [3:0] mem_addr;
  logic       core_start;
  logic       core_done = 1'b0;
  logic [3:0] address;
  logic       operation;
  logic [1:0] cmd_code;
  logic       busy;

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  btn_cmd_scheduler #(.ADDR_W(4), .ADDR_MAX(15), .STABLE_TICKS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_load    (btn_load),
    .btn_run     (btn_run),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_ack  (mem_rd_ack),
    .mem_addr    (mem_addr),
    .core_start  (core_start),
    .core_done   (core_done),
    .address     (address),
    .operation   (operation),
    .cmd_code    (cmd_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted command must match the next queued expectation.
  always @(negedge clk) begin
    if (rst && operation) begin
      if (q.size() == 0) begin
        chk("unexpected_op", 32'(cmd_code) + 32'h100, 32'h0);
      end else begin
        e = q.pop_front();
        chk("op_code", 32'(cmd_code), 32'(e.code));
        chk("op_addr", 32'(address), 32'(e.addr));
      end
    end
  end

  // Called at posedge+1; one tick cycle followed by one idle cycle.
  task automatic tick(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_load = l; btn_run = r;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic release_all();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk); k++;
    end
    #1;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  // Returns at the negedge where operation is observed high.
  task automatic wait_op();
    int k = 0;
    @(negedge clk);
    while (!operation && k < 100) begin
      @(negedge clk); k++;
    end
    chk("op_seen", 32'(operation), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(mem_rd_req), 32'd0);
    chk("rst_start", 32'(core_start), 32'd0);
    chk("rst_op", 32'(operation), 32'd0);
    chk("rst_code", 32'(cmd_code), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Bouncing DOWN, then stable: single accept, 0 wraps to 15
    q.push_back('{code: 2'd1, addr: 4'd15});
    tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0);
    tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0);
    wait_drain();
    release_all();
    chk("down_wrap_addr", 32'(address), 32'd15);

    // UP held 5 ticks from 15: one accept, wraps to 0; press again -> 1
    q.push_back('{code: 2'd0, addr: 4'd0});
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0);
    wait_drain();
    release_all();
    q.push_back('{code: 2'd0, addr: 4'd1});
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    wait_drain();
    release_all();
    chk("up_again_addr", 32'(address), 32'd1);

    // Step address up to 7
    for (int i = 0; i < 6; i++) begin
      q.push_back('{code: 2'd0, addr: 4'(i + 2)});
      for (int j = 0; j < 3; j++) tick(1, 0, 0, 0);
      release_all();
      wait_drain();
    end

    // LOAD at 7 with UP arriving while the read is in flight
    q.push_back('{code: 2'd2, addr: 4'd7});
    q.push_back('{code: 2'd0, addr: 4'd8});
    tick(0, 0, 1, 0); tick(1, 0, 1, 0); tick(1, 0, 1, 0); tick(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rd_req", 32'(mem_rd_req), 32'd1);
      chk("rd_addr", 32'(mem_addr), 32'd7);
      chk("rd_busy", 32'(busy), 32'd1);
      chk("rd_frozen", 32'(address), 32'd7);
    end
    @(posedge clk); #1;
    mem_rd_ack = 1'b1;
    @(posedge clk); #1;
    mem_rd_ack = 1'b0;
    @(negedge clk);
    chk("rd_req_drop", 32'(mem_rd_req), 32'd0);
    chk("rd_idle", 32'(busy), 32'd0);
    wait_drain();
    release_all();
    chk("after_load_addr", 32'(address), 32'd8);

    // RUN and UP on the same tick: RUN first, UP after core_done
    q.push_back('{code: 2'd3, addr: 4'd8});
    q.push_back('{code: 2'd0, addr: 4'd9});
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 1);
    wait_op();
    chk("run_start", 32'(core_start), 32'd1);
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    chk("run_start_once", 32'(core_start), 32'd0);
    chk("run_early_done_ignored", 32'(busy), 32'd1);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      chk("run_wait_busy", 32'(busy), 32'd1);
    end
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    chk("run_done_idle", 32'(busy), 32'd0);
    wait_drain();
    release_all();
    chk("after_run_addr", 32'(address), 32'd9);

    // RUN then reset while waiting for the core
    q.push_back('{code: 2'd3, addr: 4'd9});
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    wait_op();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    btn_run = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_req", 32'(mem_rd_req), 32'd0);
    chk("arst_start", 32'(core_start), 32'd0);
    chk("arst_op", 32'(operation), 32'd0);
    chk("arst_code", 32'(cmd_code), 32'd0);
    chk("arst_addr", 32'(address), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("late_done_busy", 32'(busy), 32'd0);
    end

    // Spurious ack/done in IDLE
    mem_rd_ack = 1'b1;
    core_done  = 1'b1;
    @(posedge clk); #1;
    mem_rd_ack = 1'b0;
    core_done  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("spur_busy", 32'(busy), 32'd0);
      chk("spur_req", 32'(mem_rd_req), 32'd0);
      chk("spur_op", 32'(operation), 32'd0);
    end

    // Buttons without sample_tick have no effect
    btn_up = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    btn_up = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("notick_addr", 32'(address), 32'd0);
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_cmd_scheduler.md
Name: btn_cmd_scheduler

Overview:
- Front-panel controller for the RSA board. Four push buttons (UP, DOWN, LOAD, RUN) drive one shared address register, the key-memory read port and the RSA core start/done handshake.
- Debounces and one-shots each button on a slow sample tick, then queues one pending event per button.
- A fixed-priority scheduler executes one command at a time and blocks new commands while a memory read or core run is in flight.

Parameters:
- ADDR_W, 4, width of address / mem_addr
- ADDR_MAX, 15, highest valid address; UP/DOWN wrap within 0..ADDR_MAX
- STABLE_TICKS, 3, consecutive equal samples required to accept a button level change (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-clk strobe; button sampling happens only on cycles where it is high
- btn_up  in  1  raw button level, UP
- btn_down  in  1  raw button level, DOWN
- btn_load  in  1  raw button level, LOAD key word at address
- btn_run  in  1  raw button level, RUN RSA operation
- mem_rd_req  out  1  key-memory read request, held until ack
- mem_rd_ack  in  1  read complete, one-clk pulse
- mem_addr  out  ADDR_W  read address, valid while mem_rd_req=1
- core_start  out  1  one-clk start pulse to the RSA core
- core_done  in  1  core finished, one-clk pulse
- address  out  ADDR_W  current selected address
- operation  out  1  one-clk pulse when any command is accepted
- cmd_code  out  2  command accepted with the last operation pulse: 0 UP, 1 DOWN, 2 LOAD, 3 RUN
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=0, async): all outputs 0, address=0, debounce counters cleared, stable levels=0, pending flags=0, state=IDLE.
- Debounce, per button, evaluated only when sample_tick=1:
  - If raw != stable level, increment the counter; when it reaches STABLE_TICKS, update the stable level and clear the counter.
  - If raw == stable level, clear the counter.
- Press detection: a 0->1 transition of the stable level sets that button's pending flag. The pending flag is cleared only when the scheduler consumes it. A repeat press while the flag is already set is dropped; it does not count twice.
- Scheduler priority among set pending flags: RUN > LOAD > UP > DOWN.
- State IDLE:
  - If any pending flag is set, consume the highest-priority one in this cycle.
  - Assert operation=1 and cmd_code for exactly one clk.
  - UP: address <= (address==ADDR_MAX) ? 0 : address+1. Stay in IDLE.
  - DOWN: address <= (address==0) ? ADDR_MAX : address-1. Stay in IDLE.
  - LOAD: go to RD. mem_rd_req=1 and mem_addr=address from the next cycle.
  - RUN: pulse core_start=1 for one clk in the following cycle, then go to WAIT.
- State RD:
  - Hold mem_rd_req and mem_addr stable until mem_rd_ack=1.
  - On ack, drop req in the next cycle and return to IDLE.
  - address is frozen while in RD.
- State WAIT:
  - Wait for core_done=1, then go to IDLE.
  - A core_done arriving in the same cycle as core_start is ignored; done is sampled only from the cycle after core_start.
- Throughput: at most one command is accepted per clk. UP/DOWN back-to-back accepts are allowed on consecutive clks.
- Presses during RD or WAIT set pending flags normally and are executed after return to IDLE.
- Simultaneous pending flags: the lower-priority flags stay set and are served in following IDLE cycles.
- Pending set and consume in the same clk for the same button: consume wins, flag ends 0. A new 0->1 edge is still required before the flag can set again.
- Unexpected mem_rd_ack outside RD, or core_done outside WAIT: ignored.
- Reset mid-operation: immediate return to IDLE with req/start deasserted. Pending events are lost.
- With no sample_tick, button inputs have no effect.

Decomposition:
- Shared package rsa_panel_pkg:
  - cmd_code constants CMD_UP=0, CMD_DOWN=1, CMD_LOAD=2, CMD_RUN=3
  - state encoding ST_IDLE, ST_RD, ST_START, ST_WAIT
- One sub-module, btn_debounce_edge, instantiated 4x: sample_tick-gated counter plus a rising-edge press pulse.
- Priority select, address register and FSM live in the top.

Test Plan:
- UP held 5 ticks (STABLE_TICKS=3) from address=15 -> exactly one operation pulse, cmd_code=0, address=0 (wrap); release then press again -> address=1.
- Bounce on btn_down (1,0,1,0 on successive ticks), then stable 1 for 3 ticks -> single accept, address 0 -> 15.
- LOAD at address=7, mem_rd_ack after 4 clks -> mem_rd_req high 4 clks with mem_addr=7, busy high, then IDLE; UP pressed during RD executes after, address=8.
- RUN and UP stable-pressed on the same tick -> RUN accepted first (cmd_code=3, core_start one clk later); core_done after 10 clks -> IDLE, then UP accepted.
- RUN, then rst pulled low while in WAIT -> all outputs 0 immediately; after release a late core_done is ignored and busy stays 0.
- Spurious mem_rd_ack/core_done in IDLE -> no state change, no operation pulse.
